// File: rtl/div.sv
// rtl/div.sv - iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU
// One quotient bit per cycle; result returned with its destination register.
module div #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  kill_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [ADDR_WIDTH-1:0] rd_o
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fix_q, fix_d;

  logic                  is_signed, dvd_neg, dvs_neg, ovf;
  logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs, q_fix, r_fix;
  logic [DATA_WIDTH:0]   trial, diff;

  assign is_signed = op_q[2] & ~op_q[0];
  assign dvd_neg   = is_signed & dvd_q[DATA_WIDTH-1];
  assign dvs_neg   = is_signed & dvs_q[DATA_WIDTH-1];
  assign dvd_abs   = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_abs   = dvs_neg ? -dvs_q : dvs_q;
  assign ovf       = is_signed && (dvd_q == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (&dvs_q);

  // Shift one dividend bit into the partial remainder, then trial-subtract.
  assign trial = {rem_q, quot_q[DATA_WIDTH-1]};
  assign diff  = trial - {1'b0, dvsr_q};

  // fix_q is cleared for special cases whose results are already final.
  assign q_fix = (fix_q && (dvd_neg ^ dvs_neg)) ? -quot_q : quot_q;
  assign r_fix = (fix_q && dvd_neg) ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rd_d    = rd_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    fix_d   = fix_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          op_d    = op_i;
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rd_d    = rd_i;
          state_d = S_START;
        end
      end
      S_START: begin
        if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = dvd_q;
          fix_d   = 1'b0;
          state_d = S_END;
        end else if (ovf) begin
          quot_d  = dvd_q;
          rem_d   = '0;
          fix_d   = 1'b0;
          state_d = S_END;
        end else begin
          quot_d  = dvd_abs;
          dvsr_d  = dvs_abs;
          rem_d   = '0;
          cnt_d   = '0;
          fix_d   = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!diff[DATA_WIDTH]) begin
          rem_d  = diff[DATA_WIDTH-1:0];
          quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = trial[DATA_WIDTH-1:0];
          quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = S_END;
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rd_q    <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      fix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rd_q    <= rd_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      fix_q   <= fix_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign ready_o  = (state_q == S_END);
  assign result_o = ready_o ? (op_q[1] ? r_fix : q_fix) : '0;
  assign rd_o     = ready_o ? rd_q : '0;

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div
// Vectors carry hand-computed results and ready latencies counted from the start edge.
module tb_div;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_i = '0;
  logic        kill_i = 1'b0;
  logic        busy_o, ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int total = 0;
  int bad = 0;

  div #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_i(rd_i), .kill_i(kill_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_i = rd;
  endtask

  // Starts an op now, returns at the cycle after its ready pulse.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int c;
    int found;
    logic [31:0] res;
    logic [4:0]  rdv;
    found = 0; res = '0; rdv = '0;
    launch(op, a, b, rd);
    tick();
    start_i = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
    for (c = 1; c <= 80; c++) begin
      if (ready_o) begin
        found = c; res = result_o; rdv = rd_o;
        break;
      end
      tick();
    end
    chk({tag, "_lat"}, found, lat);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_rd"}, {27'b0, rdv}, {27'b0, rd});
    tick();
    chk({tag, "_pulse"}, {31'b0, ready_o}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int seen;
    int got_c;
    logic [31:0] got_r;

    #2;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    run_op("div_m7_2", DIV, -32'sd7, 32'd2, 5'd1, 32'hFFFFFFFD, 34);
    run_op("rem_m7_2", REM, -32'sd7, 32'd2, 5'd2, 32'hFFFFFFFF, 34);
    run_op("rem_7_m2", REM, 32'd7, -32'sd2, 5'd3, 32'd1, 34);
    run_op("div_7_m2", DIV, 32'd7, -32'sd2, 5'd4, 32'hFFFFFFFD, 34);
    run_op("div_m100_m7", DIV, -32'sd100, -32'sd7, 5'd8, 32'd14, 34);
    run_op("rem_m100_m7", REM, -32'sd100, -32'sd7, 5'd9, 32'hFFFFFFFE, 34);
    run_op("divu_max_1", DIVU, 32'hFFFFFFFF, 32'd1, 5'd10, 32'hFFFFFFFF, 34);
    run_op("remu_max_16", REMU, 32'hFFFFFFFF, 32'h10, 5'd11, 32'hF, 34);
    run_op("divu_min_max", DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 34);
    run_op("divu_5_0", DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 2);
    run_op("remu_5_0", REMU, 32'd5, 32'd0, 5'd14, 32'd5, 2);
    run_op("div_m5_0", DIV, -32'sd5, 32'd0, 5'd15, 32'hFFFFFFFF, 2);
    run_op("rem_m5_0", REM, -32'sd5, 32'd0, 5'd16, 32'hFFFFFFFB, 2);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 2);
    run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0, 2);

    // Kill at cycle 10, relaunch at cycle 11.
    launch(DIVU, 32'd1000, 32'd3, 5'd7);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      if (ready_o) seen++;
    end
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_busy", {31'b0, busy_o}, 32'd0);
    chk("kill_noready", seen, 0);
    launch(DIVU, 32'd9, 32'd3, 5'd21);
    got_c = 0; got_r = '0;
    for (int c = 12; c <= 80; c++) begin
      tick();
      start_i = 1'b0;
      if (ready_o && got_c == 0) begin
        got_c = c; got_r = result_o;
      end
    end
    chk("relaunch_cyc", got_c, 45);
    chk("relaunch_res", got_r, 32'd3);

    // Kill beats start in IDLE.
    launch(DIVU, 32'd9, 32'd3, 5'd1);
    kill_i = 1'b1;
    tick();
    start_i = 1'b0; kill_i = 1'b0;
    chk("kill_start_idle", {31'b0, busy_o}, 32'd0);

    // Kill during END leaves the pulse in place.
    launch(DIVU, 32'd5, 32'd0, 5'd2);
    tick();
    start_i = 1'b0;
    tick();
    kill_i = 1'b1;
    #1;
    chk("kill_end_ready", {31'b0, ready_o}, 32'd1);
    chk("kill_end_res", result_o, 32'hFFFFFFFF);
    tick();
    kill_i = 1'b0;
    chk("kill_end_idle", {31'b0, busy_o}, 32'd0);

    // Held start: one result, next op only after END.
    launch(DIVU, 32'd100, 32'd7, 5'd3);
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready_o) seen++;
      if (c == 35) chk("held_gap", {31'b0, busy_o}, 32'd0);
      if (c == 36) chk("held_relaunch", {31'b0, busy_o}, 32'd1);
    end
    start_i = 1'b0;
    chk("held_one_result", seen, 1);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;

    // Async reset mid-operation.
    launch(DIVU, 32'd1000, 32'd3, 5'd4);
    for (int c = 1; c <= 20; c++) begin
      tick();
      start_i = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_ready", {31'b0, ready_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ready_o || busy_o) seen++;
    end
    chk("midrst_quiet", seen, 0);

    run_op("post_rst", DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
